// File: rtl/display_pkg.sv
// display_pkg: shared mode codes, source codes and FSM encoding for the display scheduler
package display_pkg;
  localparam logic [1:0] MODE_AUTO = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_CPU = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;
  localparam logic [2:0] SRC_CPU = 3'd4;
  localparam logic [2:0] SRC_NONE = 3'd7;
  typedef enum logic [1:0] {SHOW, OVERRIDE, CPUONLY, FROZEN} state_t;
endpackage

// File: rtl/display_source_scheduler_if.sv
// display_source_scheduler_if: CPU store, debug taps, controls and display output of the scheduler
interface display_source_scheduler_if;
  logic mmio_we;
  logic [15:0] mmio_wdata;
  logic [63:0] src_data;
  logic [3:0] src_valid;
  logic [1:0] mode;
  logic step_btn;
  logic [15:0] display_data;
  logic [2:0] cur_src;
  modport master (
    output mmio_we, mmio_wdata, src_data, src_valid, mode, step_btn,
    input display_data, cur_src
  );
  modport slave (
    input mmio_we, mmio_wdata, src_data, src_valid, mode, step_btn,
    output display_data, cur_src
  );
endinterface

// File: rtl/rr_next_src.sv
// rr_next_src: round-robin search for the next valid debug source after cur, wrapping to cur itself
module rr_next_src
  import display_pkg::*;
(
  input logic [2:0] cur,
  input logic [3:0] valid,
  output logic [2:0] next
);
  logic [1:0] base;
  assign base = cur[2] ? 2'd3 : cur[1:0];
  // nearest valid slot wins because the k=1 candidate is evaluated last
  always_comb begin
    next = SRC_NONE;
    for (int k = 4; k >= 1; k--)
      if (valid[base + 2'(k)]) next = {1'b0, base + 2'(k)};
  end
endmodule

// File: rtl/display_source_scheduler.sv
// display_source_scheduler: picks the 16-bit value shown on the seven-segment display
module display_source_scheduler
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int OVERRIDE_CYCLES = 200_000_000
) (
  input logic clk,
  input logic reset,
  display_source_scheduler_if.slave bus
);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int OW = $clog2(OVERRIDE_CYCLES);
  state_t state, state_n;
  logic [2:0] cur_n, saved_src, saved_n, nxt;
  logic [DW-1:0] dwell_cnt, dwell_n;
  logic [OW-1:0] ovr_cnt, ovr_n;
  logic [15:0] cpu_latch, sel;
  logic [1:0] mode_d;
  logic step_d, step_edge, cur_bad;
  rr_next_src u_rr (.cur(bus.cur_src), .valid(bus.src_valid), .next(nxt));
  assign step_edge = bus.step_btn & ~step_d;
  assign cur_bad = bus.cur_src[2] ? (bus.cur_src == SRC_NONE && |bus.src_valid)
                                  : !bus.src_valid[bus.cur_src[1:0]];
  // value feeding the display register; disabled debug sources read as blank
  always_comb
    sel = !bus.cur_src[2] ? (bus.src_valid[bus.cur_src[1:0]] ? bus.src_data[{bus.cur_src[1:0], 4'b0} +: 16] : 16'h0000)
        : bus.cur_src == SRC_CPU ? cpu_latch : 16'h0000;
  // next state: mode change first, then CPU write, invalid source, dwell/step, override timeout
  always_comb begin
    state_n = state;
    cur_n = bus.cur_src;
    saved_n = saved_src;
    dwell_n = dwell_cnt;
    ovr_n = ovr_cnt;
    if (bus.mode != mode_d) begin
      dwell_n = '0;
      ovr_n = '0;
      if (bus.mode == MODE_CPU) begin
        state_n = CPUONLY;
        cur_n = SRC_CPU;
        if (!bus.cur_src[2]) saved_n = bus.cur_src;
      end else if (bus.mode == MODE_FREEZE) state_n = FROZEN;
      else begin
        state_n = SHOW;
        if (bus.cur_src == SRC_CPU) cur_n = saved_src;
      end
    end else if (state == SHOW) begin
      if (bus.mmio_we) begin
        state_n = OVERRIDE;
        saved_n = bus.cur_src;
        cur_n = SRC_CPU;
        ovr_n = OW'(OVERRIDE_CYCLES - 1);
      end else if (cur_bad) begin
        cur_n = nxt;
        dwell_n = '0;
      end else if (bus.mode == MODE_AUTO) begin
        dwell_n = dwell_cnt == DW'(DWELL_CYCLES - 1) ? '0 : dwell_cnt + DW'(1);
        if (dwell_cnt == DW'(DWELL_CYCLES - 1)) cur_n = nxt;
      end else begin
        dwell_n = '0;
        if (step_edge) cur_n = nxt;
      end
    end else if (state == OVERRIDE) begin
      if (bus.mmio_we) ovr_n = OW'(OVERRIDE_CYCLES - 1);
      else if (ovr_cnt == '0) begin
        state_n = SHOW;
        cur_n = saved_src;
        dwell_n = '0;
      end else ovr_n = ovr_cnt - OW'(1);
    end
  end
  // state, counters, CPU latch and the display register; frozen display holds its value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SHOW;
      bus.cur_src <= '0;
      saved_src <= '0;
      dwell_cnt <= '0;
      ovr_cnt <= '0;
      cpu_latch <= '0;
      bus.display_data <= '0;
      mode_d <= MODE_AUTO;
      step_d <= 1'b0;
    end else begin
      state <= state_n;
      bus.cur_src <= cur_n;
      saved_src <= saved_n;
      dwell_cnt <= dwell_n;
      ovr_cnt <= ovr_n;
      mode_d <= bus.mode;
      step_d <= bus.step_btn;
      if (bus.mmio_we) cpu_latch <= bus.mmio_wdata;
      if (state != FROZEN) bus.display_data <= sel;
    end
  end
endmodule

// File: tb/tb_display_source_scheduler.sv
// tb_display_source_scheduler: vector table, directed corner sequences and a random run against a timestamp model
module tb_display_source_scheduler;
  localparam int D = 4;
  localparam int O = 6;
  localparam logic [63:0] PAT = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
  localparam int K_SHOW = 0, K_OVR = 1, K_CPU = 2, K_FRZ = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  display_source_scheduler_if bus();
  display_source_scheduler #(.DWELL_CYCLES(D), .OVERRIDE_CYCLES(O)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] valid;
    logic [15:0] disp;
    logic [2:0] cur;
  } vec_t;
  vec_t tbl[$];
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic add(input logic [3:0] v, input logic [15:0] d, input logic [2:0] c, input int rep = 1);
    repeat (rep) tbl.push_back('{v, d, c});
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  function automatic logic [15:0] pat16(input int k);
    return 16'(PAT >> (16 * k));
  endfunction
  // model: absolute cycle stamps for dwell expiry and override end instead of counters
  longint n = 0, due = 0, ovr_end = 0;
  logic [2:0] m_cur, m_saved;
  logic [15:0] m_disp, m_latch, m_sel;
  logic [1:0] m_mode;
  logic m_step, m_edge;
  int m_kind, m_base;
  function automatic logic [2:0] nv(input int c, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) if (v[(c + k) % 4]) return 3'((c + k) % 4);
    return 3'd7;
  endfunction
  always @(posedge clk) begin
    n++;
    if (reset) begin
      m_cur = 0; m_saved = 0; m_disp = 0; m_latch = 0; m_mode = 0; m_step = 0;
      m_kind = K_SHOW; due = n + D; ovr_end = 0;
    end else begin
      m_sel = 16'h0000;
      if (m_cur == 4) m_sel = m_latch;
      else if (m_cur < 4 && bus.src_valid[m_cur[1:0]]) m_sel = 16'(bus.src_data >> (16 * m_cur));
      if (m_kind != K_FRZ) m_disp = m_sel;
      m_edge = bus.step_btn && !m_step;
      m_step = bus.step_btn;
      m_base = (m_cur == 7) ? 3 : int'(m_cur);
      if (bus.mode != m_mode) begin
        m_mode = bus.mode;
        due = n + D;
        if (bus.mode == 2) begin
          if (m_cur < 4) m_saved = m_cur;
          m_cur = 4;
          m_kind = K_CPU;
        end else if (bus.mode == 3) m_kind = K_FRZ;
        else begin
          if (m_cur == 4) m_cur = m_saved;
          m_kind = K_SHOW;
        end
      end else if (m_kind == K_SHOW) begin
        if (bus.mmio_we) begin
          m_kind = K_OVR; m_saved = m_cur; m_cur = 4; ovr_end = n + O;
        end else if ((m_cur < 4 && !bus.src_valid[m_cur[1:0]]) || (m_cur == 7 && bus.src_valid != 0)) begin
          m_cur = nv(m_base, bus.src_valid); due = n + D;
        end else if (bus.mode == 0) begin
          if (n == due) begin
            m_cur = nv(m_base, bus.src_valid); due = n + D;
          end
        end else if (m_edge) m_cur = nv(m_base, bus.src_valid);
      end else if (m_kind == K_OVR) begin
        if (bus.mmio_we) ovr_end = n + O;
        else if (n == ovr_end) begin
          m_kind = K_SHOW; m_cur = m_saved; due = n + D;
        end
      end
      if (bus.mmio_we) m_latch = bus.mmio_wdata;
    end
  end
  // scoreboard compares every cycle away from the clock edge
  always @(negedge clk) if (!reset) begin
    check("sb_disp", bus.display_data, m_disp);
    check("sb_cur", 16'(bus.cur_src), 16'(m_cur));
  end
  initial begin
    bus.mmio_we = 0; bus.mmio_wdata = 0; bus.src_data = PAT; bus.src_valid = 4'hF;
    bus.mode = 0; bus.step_btn = 0;
    for (int i = 0; i < 20; i++) add(4'hF, pat16((i / 4) % 4), 3'(((i + 1) / 4) % 4));
    add(4'b0101, 16'h0000, 3'd2);
    add(4'b0101, 16'hCCCC, 3'd2, 3);
    add(4'b0101, 16'hCCCC, 3'd0);
    add(4'b0101, 16'hAAAA, 3'd0, 3);
    add(4'b0101, 16'hAAAA, 3'd2);
    add(4'b0101, 16'hCCCC, 3'd2, 3);
    add(4'b0101, 16'hCCCC, 3'd0);
    add(4'b0101, 16'hAAAA, 3'd0, 3);
    add(4'b0101, 16'hAAAA, 3'd2);
    add(4'b0101, 16'hCCCC, 3'd2);
    add(4'b0001, 16'h0000, 3'd0);
    add(4'b0001, 16'hAAAA, 3'd0, 2);
    tick(2);
    check("rst_disp", bus.display_data, 16'h0000);
    check("rst_cur", 16'(bus.cur_src), 16'd0);
    reset = 0;
    foreach (tbl[i]) begin
      bus.src_valid = tbl[i].valid;
      tick();
      check($sformatf("tbl%0d_disp", i), bus.display_data, tbl[i].disp);
      check($sformatf("tbl%0d_cur", i), 16'(bus.cur_src), 16'(tbl[i].cur));
    end
    bus.src_valid = 4'hF;
    do_reset();
    tick(4);
    check("ovr_pre_cur", 16'(bus.cur_src), 16'd1);
    bus.mmio_we = 1; bus.mmio_wdata = 16'h1234;
    tick();
    bus.mmio_we = 0;
    check("ovr_cur", 16'(bus.cur_src), 16'd4);
    tick();
    check("ovr_disp", bus.display_data, 16'h1234);
    tick();
    bus.mmio_we = 1; bus.mmio_wdata = 16'h5678;
    tick();
    bus.mmio_we = 0;
    tick(5);
    check("ovr_ext_cur", 16'(bus.cur_src), 16'd4);
    check("ovr_ext_disp", bus.display_data, 16'h5678);
    tick();
    check("ovr_ret_cur", 16'(bus.cur_src), 16'd1);
    tick();
    check("ovr_ret_disp", bus.display_data, 16'hBBBB);
    tick(2);
    check("ovr_dwell_hold", 16'(bus.cur_src), 16'd1);
    tick();
    check("ovr_dwell_adv", 16'(bus.cur_src), 16'd2);
    do_reset();
    bus.mode = 1;
    tick();
    bus.step_btn = 1;
    tick(10);
    check("step_once_cur", 16'(bus.cur_src), 16'd1);
    check("step_once_disp", bus.display_data, 16'hBBBB);
    bus.step_btn = 0;
    tick();
    bus.mmio_we = 1; bus.mmio_wdata = 16'h4444;
    tick();
    bus.mmio_we = 0; bus.step_btn = 1;
    tick();
    bus.step_btn = 0;
    tick();
    check("step_in_ovr", 16'(bus.cur_src), 16'd4);
    tick(4);
    check("step_ovr_ret", 16'(bus.cur_src), 16'd1);
    bus.mmio_we = 1; bus.mmio_wdata = 16'h7777; bus.step_btn = 1;
    tick();
    bus.mmio_we = 0;
    tick();
    check("we_step_cur", 16'(bus.cur_src), 16'd4);
    check("we_step_disp", bus.display_data, 16'h7777);
    tick(5);
    check("we_step_ret", 16'(bus.cur_src), 16'd1);
    bus.step_btn = 0;
    tick();
    bus.mode = 3;
    tick();
    bus.mmio_we = 1; bus.mmio_wdata = 16'hBEEF;
    tick();
    bus.mmio_we = 0;
    tick(3);
    check("frz_disp", bus.display_data, 16'hBBBB);
    check("frz_cur", 16'(bus.cur_src), 16'd1);
    bus.mode = 2;
    tick();
    check("cpu_cur", 16'(bus.cur_src), 16'd4);
    tick();
    check("cpu_disp", bus.display_data, 16'hBEEF);
    bus.mmio_we = 1; bus.mmio_wdata = 16'hC0DE;
    tick();
    bus.mmio_we = 0;
    tick();
    check("cpu_write_disp", bus.display_data, 16'hC0DE);
    bus.mode = 0;
    tick();
    check("cpu_exit_cur", 16'(bus.cur_src), 16'd1);
    tick();
    check("cpu_exit_disp", bus.display_data, 16'hBBBB);
    bus.mmio_we = 1; bus.mmio_wdata = 16'h9999;
    tick();
    bus.mmio_we = 0;
    tick();
    check("rst_ovr_pre", bus.display_data, 16'h9999);
    bus.src_valid = 4'h0;
    reset = 1;
    #1;
    check("rst_async_disp", bus.display_data, 16'h0000);
    check("rst_async_cur", 16'(bus.cur_src), 16'd0);
    tick();
    reset = 0;
    tick();
    check("rst_none_cur", 16'(bus.cur_src), 16'd7);
    check("rst_none_disp", bus.display_data, 16'h0000);
    tick();
    check("rst_none_cur2", 16'(bus.cur_src), 16'd7);
    check("rst_none_disp2", bus.display_data, 16'h0000);
    bus.src_valid = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      if (reset) reset = 0;
      else if ($urandom_range(499) == 0) reset = 1;
      bus.mmio_we = ($urandom_range(9) == 0);
      bus.mmio_wdata = 16'($urandom);
      if ($urandom_range(3) == 0) bus.step_btn = ~bus.step_btn;
      if ($urandom_range(39) == 0) bus.mode = 2'($urandom);
      if ($urandom_range(29) == 0) bus.src_valid = 4'($urandom);
      if ($urandom_range(49) == 0) bus.src_data = {$urandom, $urandom};
      tick();
    end
    reset = 0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
- Selects which 16-bit value the 4-digit seven-segment driver shows.
- Arbitrates between one CPU memory-mapped display register and four debug sources (e.g. PC, instruction, ALU result, cycle count).
- Debug sources rotate on a dwell timer or advance on a step button; a CPU write temporarily overrides them.
- Sits between the pipeline CPU/debug taps and the seven-segment driver's display_data input.

Parameters:
- DWELL_CYCLES, 100_000_000: clocks each debug source is shown in auto mode (1 s at 100 MHz); must be >= 2.
- OVERRIDE_CYCLES, 200_000_000: clocks a CPU write holds the display before returning to the debug source; must be >= 2.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- mmio_we  in  1  single-cycle CPU store strobe to the display address.
- mmio_wdata  in  16  CPU store data.
- src_data  in  64  four packed debug sources; source i is src_data[16*i+15:16*i].
- src_valid  in  4  per-source enable.
- mode  in  2  00 auto-rotate, 01 manual step, 10 CPU only, 11 freeze.
- step_btn  in  1  debounced level; the block edge-detects it.
- display_data  out  16  registered value sent to the seven-segment driver.
- cur_src  out  3  0-3 debug source, 4 CPU, 7 none.

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - display_data = 16'h0000, cur_src = 0, cpu_latch = 0, saved_src = 0.
  - dwell_cnt = 0, ovr_cnt = 0, state = SHOW, step_d = 0, mode_d = 00.
- cpu_latch loads mmio_wdata on every mmio_we, in all modes including freeze.
- display_data is registered from the current selection every cycle, so it is one cycle behind the source and tracks live changes.
  - cur_src 0-3 selects src_data slice i; cur_src 4 selects cpu_latch; cur_src 7 selects 16'h0000.
- next_valid(cur) is a round-robin search from (cur+1) mod 4 that wraps to include cur itself; it returns 7 if src_valid == 0.
- FSM states:
  - SHOW (debug source shown).
  - OVERRIDE (CPU value shown temporarily).
  - CPUONLY.
  - FROZEN.
- SHOW, auto mode (00):
  - dwell_cnt increments each clock.
  - At DWELL_CYCLES-1: cur_src <= next_valid(cur_src), dwell_cnt <= 0.
- SHOW, manual mode (01):
  - dwell_cnt is held at 0.
  - A rising edge (step_btn & ~step_d) sets cur_src <= next_valid(cur_src).
- SHOW, invalid source: if cur_src is 0-3 and src_valid[cur_src] == 0, advance to next_valid next cycle and clear dwell_cnt.
  - If cur_src == 7 and any src_valid bit is set, advance to next_valid(3), so source 0 is searched first.
- SHOW -> OVERRIDE (modes 00/01) on mmio_we:
  - saved_src <= cur_src, cur_src <= 4, ovr_cnt <= OVERRIDE_CYCLES-1.
  - mmio_we beats a same-cycle dwell expiry or step edge; both are discarded.
- OVERRIDE:
  - ovr_cnt decrements; a further mmio_we reloads it to OVERRIDE_CYCLES-1.
  - Step edges are ignored.
  - At ovr_cnt == 0 without mmio_we: state SHOW, cur_src <= saved_src, dwell_cnt <= 0. The invalid-source rule then applies.
- Mode change (mode != mode_d) takes precedence over all other events in that cycle.
  - Counters clear, any override is cancelled, and state follows the new mode.
  - Entering 00/01: cur_src <= saved_src if currently 4, else unchanged.
  - Entering 10: state CPUONLY, cur_src = 4; any debug source 0-3 is saved to saved_src first. CPU writes show one cycle after the write.
  - Entering 11: state FROZEN. display_data and cur_src hold; counters hold; cpu_latch still updates.
- Counter widths are $clog2 of the parameter. There is no overflow path because wrap happens exactly at the terminal count.
- Reset mid-override returns to SHOW with source 0 and discards the pending override.

Decomposition:
- Shared package display_pkg:
  - MODE_AUTO = 2'b00, MODE_STEP = 2'b01, MODE_CPU = 2'b10, MODE_FREEZE = 2'b11.
  - SRC_CPU = 3'd4, SRC_NONE = 3'd7.
  - FSM state encoding.
- One combinational sub-module, rr_next_src:
  - Inputs: cur[2:0], valid[3:0].
  - Output: next[2:0] implementing next_valid.
  - Reused by the auto, step, invalid-source and return paths.

Test Plan (DWELL_CYCLES=4, OVERRIDE_CYCLES=6, src_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}):
- Auto rotate, src_valid=4'b1111, mode 00 -> display_data AAAA, BBBB, CCCC, DDDD, AAAA, each held 4 cycles; cur_src wraps 3->0.
- Skip invalid, src_valid=4'b0101 -> cur_src alternates 0, 2, 0, with no BBBB or DDDD shown. Dropping src_valid[2] while source 2 is shown -> AAAA within 2 cycles.
- Override, mode 00 at source 1, mmio_we with 16'h1234 -> display_data 1234 one cycle later, cur_src 4.
  - A second write of 16'h5678 three cycles later extends the hold to 6 cycles from that write.
  - Afterwards display returns to BBBB with a fresh 4-cycle dwell.
- Manual, mode 01, step_btn held high 10 cycles -> exactly one advance. A step pulse during override -> no change. mmio_we coincident with a step edge -> override only.
- Freeze, mode 11 with mmio_we 16'hBEEF -> display_data is unchanged. Switching to mode 10 -> display_data BEEF, cur_src 4.
- Reset asserted mid-override, src_valid=0 -> display_data 0000 immediately. After release, cur_src goes 0 -> 7 and display_data stays 0000.
